// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array controller: FSM state encoding
// and the default column-0-enable-to-result latency.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    SAVE   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Skew in plus deskew out of an N x N array.
  function automatic int default_array_lat(input int array_size);
    return 2 * array_size - 1;
  endfunction

endpackage

// File: rtl/pe_skew_line.sv
// Parameterised 1-bit shift register; tap k is din_i delayed k+1 cycles.
module pe_skew_line #(
  parameter int TAPS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_i,
  output logic [TAPS-1:0] taps_o
);

  logic [TAPS-1:0] line_q;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    always_ff @(posedge clk) begin
      if (rst) begin
        line_q[gi] <= 1'b0;
      end else if (gi == 0) begin
        line_q[gi] <= din_i;
      end else begin
        line_q[gi] <= line_q[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  assign taps_o = line_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary array sequencer: weight tile load, broadcast save,
// skewed feature streaming and fixed-latency result-buffer writes.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int VEC_W      = 10,
  parameter int ARRAY_LAT  = default_array_lat(ARRAY_SIZE),
  parameter int WADDR_W    = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VEC_W-1:0]      cfg_num_vec,
  input  logic                  cfg_reuse,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [WADDR_W-1:0]    w_addr,
  output logic                  pe_save,
  output logic                  f_rd_en,
  output logic [VEC_W-1:0]      f_addr,
  output logic [ARRAY_SIZE-1:0] pe_enable,
  output logic                  o_wr_en,
  output logic [VEC_W-1:0]      o_addr
);

  localparam logic [ARRAY_LAT-1:0] WR_LAST = ARRAY_LAT'(1) << (ARRAY_LAT - 1);

  state_e               state_q, state_d;
  logic [WADDR_W-1:0]   w_cnt_q, w_cnt_d;
  logic [VEC_W-1:0]     v_cnt_q, v_cnt_d;
  logic [VEC_W-1:0]     o_cnt_q, o_cnt_d;
  logic [VEC_W-1:0]     num_vec_q, num_vec_d;
  logic [ARRAY_SIZE-1:0] en_taps;
  logic [ARRAY_LAT-1:0]  wr_taps;
  logic                  drain_pending;

  pe_skew_line #(.TAPS(ARRAY_SIZE)) u_enable_skew (
    .clk    (clk),
    .rst    (rst),
    .din_i  (f_rd_en),
    .taps_o (en_taps)
  );

  pe_skew_line #(.TAPS(ARRAY_LAT)) u_write_delay (
    .clk    (clk),
    .rst    (rst),
    .din_i  (en_taps[0]),
    .taps_o (wr_taps)
  );

  // The final write tap fires in the cycle we decide to leave DRAIN.
  assign drain_pending = (|en_taps) | (|(wr_taps & ~WR_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_cnt_q   <= '0;
      v_cnt_q   <= '0;
      o_cnt_q   <= '0;
      num_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      v_cnt_q   <= v_cnt_d;
      o_cnt_q   <= o_cnt_d;
      num_vec_q <= num_vec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    v_cnt_d   = v_cnt_q;
    o_cnt_d   = o_cnt_q;
    num_vec_d = num_vec_q;
    if (o_wr_en) o_cnt_d = o_cnt_q + VEC_W'(1);
    unique case (state_q)
      IDLE: begin
        w_cnt_d = '0;
        v_cnt_d = '0;
        o_cnt_d = '0;
        if (start) begin
          num_vec_d = cfg_num_vec;
          if (!cfg_reuse)              state_d = LOAD_W;
          else if (cfg_num_vec == '0)  state_d = DONE;
          else                         state_d = STREAM;
        end
      end
      LOAD_W: begin
        w_cnt_d = w_cnt_q + WADDR_W'(1);
        if (w_cnt_q == WADDR_W'(ARRAY_SIZE - 1)) begin
          w_cnt_d = '0;
          state_d = SAVE;
        end
      end
      SAVE: state_d = (num_vec_q == '0) ? DONE : STREAM;
      STREAM: begin
        v_cnt_d = v_cnt_q + VEC_W'(1);
        if (v_cnt_q == num_vec_q - VEC_W'(1)) begin
          v_cnt_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: if (!drain_pending) state_d = DONE;
      DONE: begin
        o_cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign w_rd_en   = (state_q == LOAD_W);
  assign w_addr    = w_cnt_q;
  assign pe_save   = (state_q == SAVE);
  assign f_rd_en   = (state_q == STREAM);
  assign f_addr    = v_cnt_q;
  assign pe_enable = en_taps;
  assign o_wr_en   = wr_taps[ARRAY_LAT-1];
  assign o_addr    = o_cnt_q;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the weight-stationary PE array. On each `start` it fetches one weight tile from weight memory and shifts it down the PE columns, then pulses a broadcast weight-save. Next it streams a programmable number of feature vectors with per-column skewed enables. It issues result-buffer writes at a fixed array latency. It sits between the PE array, its weight, feature and result memories, and the top-level command logic.

## Interface
- `ARRAY_SIZE`, 16: PE rows = PE columns (N).
- `VEC_W`, 10: width of the vector count and of the feature/result addresses.
- `ARRAY_LAT`, 2*ARRAY_SIZE-1: cycles from column-0 enable of a vector to its deskewed result at the result buffer.
- `WADDR_W`, $clog2(ARRAY_SIZE): weight address width.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle command pulse. Sampled only in IDLE.
- `cfg_num_vec` in VEC_W: number of feature vectors V. Latched at start.
- `cfg_reuse` in 1: when 1, keep the stored weights and skip weight load. Latched at start.
- `busy` out 1: high from the cycle after an accepted start through the done cycle.
- `done` out 1: one-cycle completion pulse.
- `w_rd_en` out 1, `w_addr` out WADDR_W: weight memory read. Read latency is 1 cycle.
- `pe_save` out 1: broadcast to `save` of every PE.
- `f_rd_en` out 1, `f_addr` out VEC_W: feature memory read. Read latency is 1 cycle.
- `pe_enable` out ARRAY_SIZE: bit j drives `enable` of column j.
- `o_wr_en` out 1, `o_addr` out VEC_W: result buffer write strobe and address.

## Operation
- States are IDLE, LOAD_W, SAVE, STREAM, DRAIN and DONE.
- IDLE:
  - start=1 with cfg_reuse=0 goes to LOAD_W.
  - start=1 with cfg_reuse=1 goes to STREAM.
  - start is ignored in every other state; it is neither queued nor counted.
- LOAD_W, N cycles:
  - `w_rd_en`=1 and `w_addr`=0..N-1 in increasing order.
  - Word k is destined for row N-1-k. The row skew through the PE `out_a` chain therefore aligns all rows in one cycle.
  - Goes to SAVE.
- SAVE, 1 cycle: `pe_save`=1, then go to STREAM. In that cycle every row's `in_a` holds its own weight.
- STREAM, V cycles:
  - `f_rd_en`=1 and `f_addr`=0..V-1.
  - Goes to DRAIN. If V=0, STREAM lasts 0 cycles and the FSM goes straight to DONE with no enables and no writes.
- Column-0 enable is `f_rd_en` delayed 1 cycle, matching the read latency. `pe_enable[j]` is column-0 enable delayed j further cycles, via a shift register.
- Result writes:
  - `o_wr_en` is column-0 enable delayed ARRAY_LAT cycles.
  - `o_addr` counts 0..V-1 and increments on each write.
- DRAIN: waits until the enable shift register and the write delay line are empty, then goes to DONE.
- DONE, 1 cycle: `done`=1, `busy`=1, then IDLE.
- Counters:
  - Count widths are WADDR_W and VEC_W.
  - The V count never wraps. V=2^VEC_W-1 is the maximum.
- Reset:
  - All outputs are 0, the state is IDLE, and all delay lines and counters are cleared.
  - Latched V and reuse are cleared.
  - Reset mid-operation aborts the run in the next cycle, with no done pulse. Stored PE weights are not the controller's concern.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE. Let S be the first STREAM cycle: S=N+2 without reuse, S=1 with reuse.
- Without reuse, LOAD_W occupies cycles 1..N and `pe_save` is high in cycle N+1.
- `f_rd_en` is high in cycles S..S+V-1.
- `pe_enable[j]` is high in cycles S+1+j..S+V+j.
- `o_wr_en` for vector v is in cycle S+1+v+ARRAY_LAT.
- `done` is in cycle S+V+ARRAY_LAT+1, and the next start is accepted in the cycle after that. For V=0, `done` is in cycle S.
- All outputs are registered, with no combinational path from `start` to any output.

## Structure
- The shared package/header holds the state encoding constants and the default-latency expression `2*ARRAY_SIZE-1`. The array top reuses both.
- Sub-module `pe_skew_line` is a parameterised 1-bit shift register. It is instanced once for the enable skew (ARRAY_SIZE taps) and once for the write delay (ARRAY_LAT taps).
- The FSM and counters stay in `systolic_ctrl`.

## Test plan
All scenarios use N=4, ARRAY_LAT=7.
- Reset, then idle for 10 cycles: all outputs 0 and `busy`=0 throughout.
- Start with V=3 and reuse=0:
  - `w_addr` 0,1,2,3 in cycles 1-4, and `pe_save` in cycle 5.
  - `f_addr` 0-2 in cycles 6-8.
  - `pe_enable[0]` in cycles 7-9 and `pe_enable[3]` in cycles 10-12.
  - `o_addr` 0,1,2 in cycles 14-16.
  - `done` in cycle 17.
- Start with V=2 and reuse=1:
  - No `w_rd_en` or `pe_save`.
  - `f_addr` in cycles 1-2, `o_wr_en` in cycles 9-10, `done` in cycle 11.
- Start with V=0 and reuse=0: `pe_save` in cycle 5, no enables or writes, `done` in cycle 6.
- A second start pulse in cycle 3 of a run has no effect. A start in the cycle after `done` is accepted.
- Assert `rst` in cycle 8 of the V=3 run:
  - From cycle 9, all outputs are 0, the state is IDLE and `done` never pulses.
  - A following normal run matches scenario 2.
